snake_engine: RTL

- Parametrised game core for the Snake_Game successor: it owns the snake body, direction, growth, collision and game state for a configurable grid.
- Sits between the button/pause front end and the VGA/LED renderer.
- Adds what the fixed-size game lacks: grid size, maximum length, step rate and wrap/wall mode as parameters; a food/grow handshake; a restart input; a registered pixel-query port.

---
 rtl/snake_pkg.sv | 34 +++
 rtl/snake_tick_gen.sv | 31 +++
 rtl/snake_engine.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared encodings and helpers for the snake game core.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DEAD  = 2'd3
    } state_t;

    function automatic dir_t reverse_dir(input dir_t d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

    // Counter width that stays legal for a modulus of 1.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Move-rate divider: counts 0..TICK_DIV-1 while enabled and flags the wrap cycle.
module snake_tick_gen
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int CW = width_of(TICK_DIV);

    logic [CW-1:0] cnt;

    assign wrap = en && (cnt == CW'(TICK_DIV - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/snake_engine.sv
// Snake game core: body shift register, steering, growth, collision and game state.
module snake_engine
    import snake_pkg::*;
#(
    parameter int GRID_W    = 16,
    parameter int GRID_H    = 12,
    parameter int MAX_LEN   = 32,
    parameter int INIT_LEN  = 3,
    parameter int TICK_DIV  = 5000,
    parameter int WRAP_MODE = 0,
    parameter int SCORE_W   = 8
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [3:0]                   i_Push,
    input  logic                         i_Pause,
    input  logic                         i_Restart,
    input  logic [$clog2(GRID_W)-1:0]    i_FoodX,
    input  logic [$clog2(GRID_H)-1:0]    i_FoodY,
    input  logic                         i_FoodValid,
    input  logic [$clog2(GRID_W)-1:0]    i_QueryX,
    input  logic [$clog2(GRID_H)-1:0]    i_QueryY,
    output logic                         o_QueryHit,
    output logic                         o_QueryHead,
    output logic [$clog2(GRID_W)-1:0]    o_HeadX,
    output logic [$clog2(GRID_H)-1:0]    o_HeadY,
    output logic [$clog2(MAX_LEN+1)-1:0] o_Length,
    output logic [SCORE_W-1:0]           o_Score,
    output logic [STATE_W-1:0]           o_State,
    output logic                         o_Step,
    output logic                         o_Eat
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int LW = $clog2(MAX_LEN + 1);

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } cell_t;

    function automatic cell_t init_cell(input int i);
        cell_t c;
        c.x = XW'(GRID_W / 2 - i);
        c.y = YW'(GRID_H / 2);
        return c;
    endfunction

    cell_t         seg [MAX_LEN];
    state_t        state;
    dir_t          dir;
    dir_t          pending;
    logic [LW-1:0] len;
    logic [SCORE_W-1:0] score;

    logic  tick_en, tick_wrap;
    logic  pressed, press_ok, off_grid, grow, self_hit, q_hit, q_head;
    dir_t  press_dir, step_dir;
    cell_t next_head, query;
    int    nx, ny, hit_lim;

    assign tick_en = (state == ST_RUN) && !i_Pause && !i_Restart;

    snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (Clk),
        .rst  (Rst),
        .en   (tick_en),
        .clr  (i_Restart),
        .wrap (tick_wrap)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pressed   = (i_Push != 4'hF);
        press_dir = DIR_RIGHT;
        if (!i_Push[0])      press_dir = DIR_UP;
        else if (!i_Push[1]) press_dir = DIR_DOWN;
        else if (!i_Push[2]) press_dir = DIR_LEFT;
        press_ok = tick_en && pressed && (press_dir != reverse_dir(dir));
        step_dir = press_ok ? press_dir : pending;

        nx = int'(seg[0].x);
        ny = int'(seg[0].y);
        case (step_dir)
            DIR_UP:   ny = ny - 1;
            DIR_DOWN: ny = ny + 1;
            DIR_LEFT: nx = nx - 1;
            default:  nx = nx + 1;
        endcase
        off_grid = 1'b0;
        if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) begin
            if (WRAP_MODE != 0) begin
                nx = (nx < 0) ? GRID_W - 1 : (nx >= GRID_W) ? 0 : nx;
                ny = (ny < 0) ? GRID_H - 1 : (ny >= GRID_H) ? 0 : ny;
            end else begin
                off_grid = 1'b1;
            end
        end
        next_head.x = XW'(nx);
        next_head.y = YW'(ny);

        grow = i_FoodValid && !off_grid && (next_head.x == i_FoodX) && (next_head.y == i_FoodY);
        // The tail cell is free to enter unless this move grows the body.
        hit_lim  = grow ? int'(len) : int'(len) - 1;
        self_hit = 1'b0;
        query.x  = i_QueryX;
        query.y  = i_QueryY;
        q_hit    = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < hit_lim && seg[i] == next_head) self_hit = 1'b1;
            if (i < int'(len) && seg[i] == query) q_hit = 1'b1;
        end
        q_head = (seg[0] == query);
    end

    // NOTE: the segment array is reset because restart must rebuild the exact reset body.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= ST_IDLE;
            dir         <= DIR_RIGHT;
            pending     <= DIR_RIGHT;
            len         <= LW'(INIT_LEN);
            score       <= '0;
            o_Step      <= 1'b0;
            o_Eat       <= 1'b0;
            o_QueryHit  <= 1'b0;
            o_QueryHead <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) seg[i] <= init_cell(i);
        end else if (i_Restart) begin
            state       <= ST_IDLE;
            dir         <= DIR_RIGHT;
            pending     <= DIR_RIGHT;
            len         <= LW'(INIT_LEN);
            score       <= '0;
            o_Step      <= 1'b0;
            o_Eat       <= 1'b0;
            o_QueryHit  <= 1'b0;
            o_QueryHead <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) seg[i] <= init_cell(i);
        end else begin
            o_Step      <= 1'b0;
            o_Eat       <= 1'b0;
            o_QueryHit  <= q_hit;
            o_QueryHead <= q_head;
            case (state)
                ST_IDLE: if (pressed) state <= ST_RUN;
                ST_RUN: begin
                    if (i_Pause) begin
                        state <= ST_PAUSE;
                    end else if (tick_wrap) begin
                        dir     <= step_dir;
                        pending <= step_dir;
                        if (off_grid || self_hit) begin
                            state <= ST_DEAD;
                        end else begin
                            for (int i = 1; i < MAX_LEN; i++) seg[i] <= seg[i-1];
                            seg[0] <= next_head;
                            o_Step <= 1'b1;
                            if (grow) begin
                                o_Eat <= 1'b1;
                                if (len != LW'(MAX_LEN)) len <= len + 1'b1;
                                if (score != '1) score <= score + 1'b1;
                            end
                        end
                    end else if (press_ok) begin
                        pending <= press_dir;
                    end
                end
                ST_PAUSE: if (!i_Pause) state <= ST_RUN;
                default: ;
            endcase
        end
    end

    assign o_HeadX  = seg[0].x;
    assign o_HeadY  = seg[0].y;
    assign o_Length = len;
    assign o_Score  = score;
    assign o_State  = state;

endmodule
